// File: rtl/lidar_link_pkg.sv
// Shared LiDAR link definitions: header bytes, frame size, TX FSM states, payload checksum.
// Frame size depends on RESULT_TX_CHECKSUM_EN (9 bytes when defined, 8 otherwise).
package lidar_link_pkg;

  localparam logic [7:0] LINK_HDR_A = 8'h55;
  localparam logic [7:0] LINK_HDR_B = 8'hAA;

`ifdef RESULT_TX_CHECKSUM_EN
  localparam logic [3:0] FRAME_BYTES = 4'd9;
`else
  localparam logic [3:0] FRAME_BYTES = 4'd8;
`endif

  localparam logic [3:0] LAST_BYTE_IDX = FRAME_BYTES - 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_BYTE,
    ST_FINISH
  } tx_state_t;

  // Modulo-256 sum of the six payload bytes; headers are not included.
  function automatic logic [7:0] payload_checksum(input logic [15:0] w0,
                                                  input logic [15:0] w1,
                                                  input logic [15:0] w2);
    logic [7:0] sum;
    sum = w0[7:0] + w0[15:8] + w1[7:0] + w1[15:8] + w2[7:0] + w2[15:8];
    return sum;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: baud counter plus 10-bit shift register, LSB first, line idles high.
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
  end

  logic [9:0]    shift_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic          busy_q;
  logic          last_cycle;
  logic          accept;

  // byte_done fires one cycle before the stop bit ends; a start offered in that final
  // stop cycle is accepted so consecutive bytes leave no idle gap on the line.
  assign last_cycle = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_LAST);
  assign byte_done  = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_PEN);
  assign accept     = start && (!busy_q || last_cycle);
  assign busy       = busy_q;
  assign tx         = shift_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      shift_q <= {1'b1, data, 1'b0};
      cnt_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        shift_q <= {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_packet_tx.sv
// LiDAR result packet transmitter: latches a result set on sendData and sends it as a UART frame.
// Define RESULT_TX_CHECKSUM_EN to append a payload checksum byte to every frame.
module result_packet_tx
  import lidar_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HDR_A        = LINK_HDR_A,
  parameter logic [7:0]  HDR_B        = LINK_HDR_B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] max_distance_angle,
  input  logic [15:0] min_distance_angle,
  input  logic [15:0] obs_alert,
  input  logic        sendData,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  tx_state_t   state_q, state_d;
  logic [3:0]  idx_q;
  logic [15:0] max_q, min_q, obs_q;
  logic        overrun_q;
  logic        ser_start;
  logic [7:0]  ser_byte;
  logic        ser_busy;
  logic        ser_byte_done;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (ser_start),
    .data      (ser_byte),
    .busy      (ser_busy),
    .tx        (tx),
    .byte_done (ser_byte_done)
  );

  always_comb begin
    ser_byte = HDR_A;
    case (idx_q)
      4'd0:    ser_byte = HDR_A;
      4'd1:    ser_byte = HDR_B;
      4'd2:    ser_byte = max_q[7:0];
      4'd3:    ser_byte = max_q[15:8];
      4'd4:    ser_byte = min_q[7:0];
      4'd5:    ser_byte = min_q[15:8];
      4'd6:    ser_byte = obs_q[7:0];
      4'd7:    ser_byte = obs_q[15:8];
`ifdef RESULT_TX_CHECKSUM_EN
      4'd8:    ser_byte = payload_checksum(max_q, min_q, obs_q);
`endif
      default: ser_byte = HDR_A;
    endcase
  end

  // After the last byte's byte_done, idx steps past the end and SEND_BYTE holds one more
  // cycle so FINISH lines up with the cycle after the final stop bit.
  always_comb begin
    state_d   = state_q;
    ser_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sendData) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ser_start = 1'b1;
        state_d   = ST_SEND_BYTE;
      end
      ST_SEND_BYTE: begin
        if (idx_q == FRAME_BYTES) begin
          state_d = ST_FINISH;
        end else if (ser_byte_done && (idx_q != LAST_BYTE_IDX)) begin
          state_d = ST_LOAD;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      obs_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= sendData && (state_q != ST_IDLE);
      if ((state_q == ST_IDLE) && sendData) begin
        max_q <= max_distance_angle;
        min_q <= min_distance_angle;
        obs_q <= obs_alert;
        idx_q <= '0;
      end else if ((state_q == ST_SEND_BYTE) && ser_byte_done) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  assign busy    = (state_q == ST_LOAD) || (state_q == ST_SEND_BYTE) || ser_busy;
  assign done    = (state_q == ST_FINISH);
  assign overrun = overrun_q;

endmodule
